// File: rtl/rsa_frame_pkg.sv
// Shared types and constants for the RSA RX frame reader.
package rsa_frame_pkg;

    // Read-side sequencer states.
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        OUT     = 3'd4
    } state_e;

    // Drop reasons reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // True while a frame is partially received and may stall.
    function automatic logic in_frame(input state_e s);
        return (s == LEN) || (s == PAYLOAD) || (s == CHK);
    endfunction

endpackage

// File: rtl/frame_idle_timer.sv
// Idle counter for an in-progress frame: counts enabled cycles, fires when
// the count reaches TIMEOUT_CYCLES and restarts from zero on clear or expiry.
module frame_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Expiry is flagged on the edge that would make the count reach the limit.
    assign expire_o = en_i && !clr_i && (count_q == LAST_COUNT);

    // Next count: clear wins, then expiry restart, then increment.
    always_comb begin
        count_d = count_q;
        if (clr_i || expire_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rsa_frame_reader.sv
// Pops the RX byte FIFO, finds SYNC, parses LEN/payload/CHK and presents the
// payload as a right-aligned big-endian operand; bad frames are dropped and
// counted.
module rsa_frame_reader
    import rsa_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic [4:0]           frame_len,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [7:0]           err_count
);

    localparam int unsigned W         = 8 * MAX_LEN;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [4:0]     len_q, len_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [7:0]     acc_q, acc_d;
    logic           err_pulse_q, err_pulse_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [7:0]     err_count_q, err_count_d;

    logic           active;
    logic           timer_expire;
    logic           err_raise;
    logic [1:0]     err_kind;

    assign active      = in_frame(state_q);
    // The FIFO is never read while a frame waits for the RSA core.
    assign fifo_rd_en  = !fifo_empty && (state_q != OUT);

    assign frame_data  = data_q;
    assign frame_len   = len_q;
    assign frame_valid = (state_q == OUT);
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign err_count   = err_count_q;

    // Idle timer only runs mid-frame and restarts on every pop.
    frame_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (fifo_rd_en || !active),
        .en_i     (active && fifo_empty),
        .expire_o (timer_expire)
    );

    // Frame parser next-state and error reporting.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        err_raise   = 1'b0;
        err_kind    = ERR_NONE;

        case (state_q)
            HUNT: begin
                if (fifo_rd_en && (fifo_data == SYNC_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (fifo_rd_en) begin
                    if ((fifo_data == 8'd0) || (fifo_data > MAX_LEN_B)) begin
                        err_raise = 1'b1;
                        err_kind  = ERR_LEN;
                        state_d   = HUNT;
                    end else begin
                        len_d   = fifo_data[4:0];
                        data_d  = '0;
                        cnt_d   = '0;
                        acc_d   = fifo_data;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (fifo_rd_en) begin
                    // Shift-in keeps the first byte most significant.
                    data_d = (data_q << 8) | W'(fifo_data);
                    acc_d  = acc_q ^ fifo_data;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_d == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (fifo_rd_en) begin
                    if (fifo_data == acc_q) begin
                        state_d = OUT;
                    end else begin
                        err_raise = 1'b1;
                        err_kind  = ERR_CHK;
                        state_d   = HUNT;
                    end
                end
            end
            OUT: begin
                if (frame_ready) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        // Expiry only happens with the FIFO empty, so it never races a pop.
        if (timer_expire) begin
            err_raise = 1'b1;
            err_kind  = ERR_TIMEOUT;
            state_d   = HUNT;
        end

        if (err_raise) begin
            err_pulse_d = 1'b1;
            err_code_d  = err_kind;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            data_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_rsa_frame_reader.sv
// Scoreboard bench for rsa_frame_reader: a queue-based FIFO model feeds the
// DUT, the stimulus side predicts each frame/error from the frame rules, and
// a monitor pops predictions as the DUT presents results.
module tb_rsa_frame_reader;

    localparam int MAXL = 16;
    localparam int W    = 8 * MAXL;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [7:0]     fifo_data;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [W-1:0]   frame_data;
    logic [4:0]     frame_len;
    logic           frame_valid;
    logic           frame_ready;
    logic           err_pulse;
    logic [1:0]     err_code;
    logic [7:0]     err_count;

    always #5 clk = ~clk;

    rsa_frame_reader dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .frame_data  (frame_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
        int           len;
        int           code;
        int           count;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] push_q[$];
    logic [7:0] pbuf [16];
    bit         pop_flag    = 1'b0;
    bit         ready_force = 1'b1;
    bit         ready_val   = 1'b1;
    int         model_errs  = 0;
    int         errors      = 0;
    int         checks      = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // FIFO model: apply the pop seen at the last edge, accept pushes, drive head.
    initial begin
        fifo_empty  = 1'b1;
        fifo_data   = 8'h00;
        frame_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            frame_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
            fifo_empty  = (fifo_q.size() == 0);
            fifo_data   = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
            #3;
            pop_flag = fifo_rd_en;
        end
    end

    // Monitor: pops a prediction for every accepted frame or error pulse.
    initial begin
        bit           hold_active;
        logic [W-1:0] hold_data;
        exp_t         e;
        hold_active = 1'b0;
        hold_data   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                hold_active = 1'b0;
            end else begin
                if (frame_valid) begin
                    check("no_pop_in_out", fifo_rd_en, 0);
                    if (!hold_active) begin
                        hold_active = 1'b1;
                        hold_data   = frame_data;
                    end else begin
                        check("hold_stable", frame_data, hold_data);
                    end
                    if (frame_ready) begin
                        hold_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_frame: got len %0d data %0h, expected nothing", frame_len, frame_data);
                        end else begin
                            e = exp_q.pop_front();
                            $display("frame  len=%0d data=%0h", frame_len, frame_data);
                            check("frame_kind", 0, e.is_err);
                            check("frame_data", frame_data, e.data);
                            check("frame_len", frame_len, e.len);
                        end
                    end
                end else begin
                    hold_active = 1'b0;
                end
                if (err_pulse) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_err: got code %0d count %0d, expected nothing", err_code, err_count);
                    end else begin
                        e = exp_q.pop_front();
                        $display("error  code=%0d count=%0d", err_code, err_count);
                        check("err_kind", 1, e.is_err);
                        check("err_code", err_code, e.code);
                        check("err_count", err_count, e.count);
                    end
                end
            end
        end
    end

    task automatic expect_err(input int code);
        exp_t e;
        model_errs = (model_errs < 255) ? model_errs + 1 : 255;
        e = '{1'b1, '0, 0, code, model_errs};
        exp_q.push_back(e);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
            push_q.push_back(b);
        end
    endtask

    // Full frame; a nonzero chk_flip corrupts the checksum byte.
    task automatic send_frame(input int len, input logic [7:0] pay [16], input logic [7:0] chk_flip);
        logic [7:0]   chk;
        logic [W-1:0] op;
        exp_t         e;
        chk = 8'(len);
        op  = '0;
        for (int i = 0; i < len; i++) begin
            chk = chk ^ pay[i];
            op  = (op << 8) | W'(pay[i]);
        end
        if (chk_flip != 0) begin
            expect_err(2);
        end else begin
            e = '{1'b0, op, len, 0, 0};
            exp_q.push_back(e);
        end
        push_q.push_back(8'hA5);
        push_q.push_back(8'(len));
        for (int i = 0; i < len; i++) push_q.push_back(pay[i]);
        push_q.push_back(chk ^ chk_flip);
    endtask

    task automatic send_badlen(input logic [7:0] len);
        expect_err(1);
        push_q.push_back(8'hA5);
        push_q.push_back(len);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        for (cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && push_q.size() == 0) break;
        end
        if (cyc >= 6000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, frame_valid, 0);
        check({tag, "_data"}, frame_data, 0);
        check({tag, "_len"}, frame_len, 0);
        check({tag, "_pulse"}, err_pulse, 0);
        check({tag, "_code"}, err_code, 0);
        check({tag, "_count"}, err_count, 0);
        check({tag, "_rd_en"}, fifo_rd_en, !fifo_empty);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           kind;
        int           len;
        logic [7:0]   flip;
        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Good frame A5 02 12 34 24.
        ready_force = 1'b1; ready_val = 1'b1;
        pbuf = '{default: 8'h00};
        pbuf[0] = 8'h12; pbuf[1] = 8'h34;
        send_frame(2, pbuf, 8'h00);
        wait_idle("good");
        check("fifo_drained", fifo_empty, 1);
        check("count_after_good", err_count, 0);

        // Leading garbage and 10+ cycles of backpressure.
        ready_val = 1'b0;
        push_q.push_back(8'h00);
        push_q.push_back(8'hFF);
        pbuf[0] = 8'h7E;
        send_frame(1, pbuf, 8'h00);
        repeat (18) @(negedge clk);
        #2;
        check("held_valid", frame_valid, 1);
        check("held_data", frame_data, 128'h7E);
        ready_val = 1'b1;
        wait_idle("backpressure");

        // Bad checksum, then two bad lengths.
        pbuf[0] = 8'h12; pbuf[1] = 8'h34;
        send_frame(2, pbuf, 8'h01);
        send_badlen(8'h00);
        send_badlen(8'h11);
        wait_idle("errors");

        // Timeout mid-payload, then a good frame.
        expect_err(3);
        push_q.push_back(8'hA5);
        push_q.push_back(8'h03);
        push_q.push_back(8'h11);
        wait_idle("timeout");
        pbuf[0] = 8'hC3; pbuf[1] = 8'hA5; pbuf[2] = 8'h5C;
        send_frame(3, pbuf, 8'h00);
        wait_idle("after_timeout");

        // Randomized traffic with random backpressure.
        ready_force = 1'b0;
        for (int f = 0; f < 40; f++) begin
            send_garbage($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            if (kind <= 7) begin
                len = $urandom_range(1, MAXL);
                for (int i = 0; i < MAXL; i++) pbuf[i] = 8'($urandom_range(0, 255));
                flip = (kind <= 5) ? 8'h00 : 8'($urandom_range(1, 255));
                send_frame(len, pbuf, flip);
            end else begin
                send_badlen(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end
        end
        wait_idle("random");

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send_badlen(8'h00);
        wait_idle("saturate");
        check("count_saturated", err_count, 255);

        // Reset while stalled mid-payload, then a full-length frame.
        ready_force = 1'b1; ready_val = 1'b1;
        push_q.push_back(8'hA5);
        push_q.push_back(8'h10);
        push_q.push_back(8'h01);
        push_q.push_back(8'h02);
        push_q.push_back(8'h03);
        wait_idle("pre_reset");
        rst = 1'b0;
        #2;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_errs = 0;
        for (int i = 0; i < MAXL; i++) pbuf[i] = 8'(i + 1);
        send_frame(MAXL, pbuf, 8'h00);
        wait_idle("full_len");
        check("full_len_count", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
